// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared constants for the NAND half-subtractor core
// Purpose: default lane count and the per-lane truth table, indexed by {a,b}.
// Ports: none (package).
package hs_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Bit {a,b} of each table is the expected lane output for that input pair:
  // 00->0/0, 01->1/1, 10->1/0, 11->0/0 (diff/bout).
  localparam logic [3:0] HS_DIFF_TT = 4'b0110;
  localparam logic [3:0] HS_BOUT_TT = 4'b0010;

  function automatic logic [1:0] hs_lookup(input logic a, input logic b);
    logic [3:0] dt;
    logic [3:0] bt;
    dt = HS_DIFF_TT;
    bt = HS_BOUT_TT;
    return {dt[{a, b}], bt[{a, b}]};
  endfunction

endpackage

// File: rtl/hs_nand_cell.sv
// rtl/hs_nand_cell.sv - single-lane half subtractor built from seven 2-input NANDs
// Purpose: diff = a ^ b, bout = ~a & b, using gate primitives only.
// Ports: a, b (lane inputs); diff, bout (combinational lane outputs).
module hs_nand_cell (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic bout
);

  wire n1;
  wire n2;
  wire n3;
  wire n_diff;
  wire na;
  wire n4;
  wire n_bout;

  // XOR from the classic four-NAND arrangement.
  nand g_n1   (n1, a, b);
  nand g_n2   (n2, a, n1);
  nand g_n3   (n3, b, n1);
  nand g_diff (n_diff, n2, n3);

  // ~a & b: invert a with a tied NAND, NAND with b, then invert the result.
  nand g_na   (na, a, a);
  nand g_n4   (n4, na, b);
  nand g_bout (n_bout, n4, n4);

  assign diff = n_diff;
  assign bout = n_bout;

endmodule

// File: rtl/hs_nand_core.sv
// rtl/hs_nand_core.sv - WIDTH-lane NAND half subtractor with registered copy
// Purpose: independent per-lane half subtraction; combinational outputs plus
//          a one-cycle registered copy qualified by in_valid.
// Ports: clk, rst_n (async active-low); a, b, in_valid (inputs);
//        diff, bout (combinational); diff_q, bout_q, out_valid (registered).
module hs_nand_core
  import hs_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] bout,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] bout_q,
  output logic             out_valid
);

  wire [WIDTH-1:0] diff_c;
  wire [WIDTH-1:0] bout_c;

  // Lanes share nothing: no borrow chain between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    hs_nand_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .diff (diff_c[i]),
      .bout (bout_c[i])
    );
  end

  // Combinational outputs do not depend on clk or rst_n.
  assign diff = diff_c;
  assign bout = bout_c;

  // Data holds when in_valid is low; only the valid flag drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      bout_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        diff_q <= diff_c;
        bout_q <= bout_c;
      end
    end
  end

endmodule

// File: tb/tb_hs_nand_core.sv
// tb/tb_hs_nand_core.sv - self-checking bench for hs_nand_core (WIDTH 1 and 4)
module tb_hs_nand_core;
  import hs_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:0] a1, b1;
  logic       iv1;
  logic [0:0] d1, bo1, dq1, bq1;
  logic       ov1;
  logic [3:0] a4, b4;
  logic       iv4;
  logic [3:0] d4, bo4, dq4, bq4;
  logic       ov4;

  int total;
  int passed;

  hs_nand_core #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .diff(d1), .bout(bo1), .diff_q(dq1), .bout_q(bq1), .out_valid(ov1)
  );

  hs_nand_core #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4),
    .diff(d4), .bout(bo4), .diff_q(dq4), .bout_q(bq4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: lane difference is the parity of a+b, borrow when b > a.
  function automatic logic [3:0] m_diff(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = ((int'(a[i]) + int'(b[i])) % 2) == 1;
    return r;
  endfunction

  function automatic logic [3:0] m_bout(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = int'(b[i]) > int'(a[i]);
    return r;
  endfunction

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic bout;
  } vec_t;

  vec_t vecs[4];

  logic [3:0] exp_dq, exp_bq;
  logic       exp_ov;
  logic [1:0] tt;

  initial begin
    total = 0;
    passed = 0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
    a4 = 4'h0; b4 = 4'h0; iv4 = 1'b1;
    #2;
    check("reset_diff_q", 32'(dq1), 32'd0);
    check("reset_bout_q", 32'(bq1), 32'd0);
    check("reset_out_valid", 32'(ov1), 32'd0);
    check("reset_comb_diff", 32'(d1), 32'd1);
    @(posedge clk); #1;
    check("reset_hold_ov", 32'(ov1), 32'd0);
    check("reset_hold_dq4", 32'(dq4), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    iv1 = 1'b0;
    iv4 = 1'b0;

    // Truth table, WIDTH=1.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = vecs[i].a; b1 = vecs[i].b;
      @(posedge clk); #1;
      check($sformatf("tt_diff_%0d", i), 32'(d1), 32'(vecs[i].diff));
      check($sformatf("tt_bout_%0d", i), 32'(bo1), 32'(vecs[i].bout));
    end

    // Capture then hold.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; iv1 = 1'b1;
    @(posedge clk); #1;
    check("cap_diff_q", 32'(dq1), 32'd1);
    check("cap_bout_q", 32'(bq1), 32'd1);
    check("cap_out_valid", 32'(ov1), 32'd1);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
    @(posedge clk); #1;
    check("hold_diff_q", 32'(dq1), 32'd1);
    check("hold_bout_q", 32'(bq1), 32'd1);
    check("hold_out_valid", 32'(ov1), 32'd0);

    // Asynchronous reset between edges, with a pending valid input.
    @(negedge clk);
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_diff_q", 32'(dq1), 32'd0);
    check("async_bout_q", 32'(bq1), 32'd0);
    check("async_out_valid", 32'(ov1), 32'd0);
    check("async_comb_diff", 32'(d1), 32'd1);
    check("async_comb_bout", 32'(bo1), 32'd0);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    check("async_comb_bout2", 32'(bo1), 32'd1);
    @(posedge clk); #1;
    check("async_discard_ov", 32'(ov1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("release_diff_q", 32'(dq1), 32'd1);
    check("release_bout_q", 32'(bq1), 32'd0);
    check("release_out_valid", 32'(ov1), 32'd1);

    // No cross-lane borrow.
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b0;
    #1;
    check("w4_diff", 32'(d4), 32'b0110);
    check("w4_bout", 32'(bo4), 32'b0010);

    // Exhaustive WIDTH=4 with in_valid held high.
    iv4 = 1'b1;
    for (int p = 0; p < 256; p++) begin
      @(negedge clk);
      a4 = p[7:4]; b4 = p[3:0];
      #1;
      check("ex_diff", 32'(d4), 32'(m_diff(a4, b4)));
      check("ex_bout", 32'(bo4), 32'(m_bout(a4, b4)));
      for (int l = 0; l < 4; l++) begin
        tt = hs_lookup(a4[l], b4[l]);
        check("ex_lane_tt", 32'({d4[l], bo4[l]}), 32'(tt));
      end
      @(posedge clk); #1;
      check("ex_diff_q", 32'(dq4), 32'(m_diff(a4, b4)));
      check("ex_bout_q", 32'(bq4), 32'(m_bout(a4, b4)));
      check("ex_out_valid", 32'(ov4), 32'd1);
    end

    // Random stimulus against a hold/capture scoreboard.
    exp_dq = dq4 === m_diff(a4, b4) ? m_diff(a4, b4) : 4'hx;
    exp_bq = m_bout(a4, b4);
    exp_dq = m_diff(a4, b4);
    for (int r = 0; r < 300; r++) begin
      @(negedge clk);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      iv4 = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (iv4) begin
        exp_dq = m_diff(a4, b4);
        exp_bq = m_bout(a4, b4);
      end
      exp_ov = iv4;
      #1;
      check("rnd_diff_q", 32'(dq4), 32'(exp_dq));
      check("rnd_bout_q", 32'(bq4), 32'(exp_bq));
      check("rnd_out_valid", 32'(ov4), 32'(exp_ov));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
